// File: rtl/vend_pkg.sv
// Shared types, error codes and price table for the vending transaction controller.
package vend_pkg;
    localparam int TYPE_W    = 3;
    localparam int NUM_TYPES = 8;
    localparam int COST_W    = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_RESTOCK  = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    localparam logic [2:0] ERR_OK         = 3'd0;
    localparam logic [2:0] ERR_BAD_QTY    = 3'd1;
    localparam logic [2:0] ERR_NO_STOCK   = 3'd2;
    localparam logic [2:0] ERR_NO_FUNDS   = 3'd3;
    localparam logic [2:0] ERR_MONEY_OVF  = 3'd4;
    localparam logic [2:0] ERR_STOCK_FULL = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd6;

    function automatic logic [COST_W-1:0] price_of(input logic [TYPE_W-1:0] t);
        logic [COST_W-1:0] p;
        case (t)
            3'd0:    p = 11'd5;
            3'd1:    p = 11'd8;
            3'd2:    p = 11'd10;
            3'd3:    p = 11'd12;
            3'd4:    p = 11'd15;
            3'd5:    p = 11'd20;
            3'd6:    p = 11'd25;
            3'd7:    p = 11'd30;
            default: p = 11'd0;
        endcase
        return p;
    endfunction

    function automatic logic [COST_W-1:0] calc_cost(input logic [TYPE_W-1:0] t,
                                                    input logic [COST_W-1:0] qty);
        return price_of(t) * qty;
    endfunction
endpackage

// File: rtl/vend_stock_bank.sv
// Eight per-type stock counters with a read port, a decrement port and an overflow-checked add port.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int STOCK_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TYPE_W-1:0]  rd_type,
    output logic [STOCK_W-1:0] rd_data,
    input  logic               dec_en,
    input  logic [TYPE_W-1:0]  dec_type,
    input  logic               add_en,
    input  logic [TYPE_W-1:0]  add_type,
    input  logic [STOCK_W-1:0] add_qty,
    output logic               add_ovf
);
    logic [STOCK_W-1:0] stock_r [NUM_TYPES];
    logic [STOCK_W:0]   add_sum_s;

    // Read port plus one-bit-wider sum so a full counter is never wrapped
    always_comb begin
        rd_data   = stock_r[rd_type];
        add_sum_s = {1'b0, stock_r[add_type]} + {1'b0, add_qty};
        add_ovf   = add_sum_s[STOCK_W];
    end

    // Counter update; an overflowing add leaves the counter untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TYPES; i++) stock_r[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TYPES; i++) begin
                if (dec_en && dec_type == TYPE_W'(i))
                    stock_r[i] <= stock_r[i] - STOCK_W'(1);
                else if (add_en && !add_ovf && add_type == TYPE_W'(i))
                    stock_r[i] <= add_sum_s[STOCK_W-1:0];
            end
        end
    end
endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: arbitrates purchase/restock ports, checks, dispenses, returns change.
// Optional dispenser stall timeout is built when VEND_DISP_TIMEOUT_EN is defined.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int STOCK_W     = 4,
    parameter int MONEY_W     = 7,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cust_req,
    input  logic [2:0]         cust_type,
    input  logic [STOCK_W-1:0] cust_qty,
    input  logic [MONEY_W-1:0] cust_money,
    output logic               cust_ack,
    input  logic               op_req,
    input  logic [2:0]         op_type,
    input  logic [STOCK_W-1:0] op_qty,
    output logic               op_ack,
    output logic               disp_valid,
    output logic [2:0]         disp_type,
    input  logic               disp_ready,
    output logic [MONEY_W-1:0] change,
    output logic               change_valid,
    output logic               done,
    output logic [2:0]         err_code,
    output logic [MONEY_W-1:0] machine_money,
    output logic               busy
);
    localparam logic [COST_W-1:0] MONEY_MAX = COST_W'((1 << MONEY_W) - 1);

    state_t             state_r, state_s;
    logic               is_cust_r, is_cust_s, prio_op_r, prio_op_s;
    logic [TYPE_W-1:0]  type_r, type_s;
    logic [STOCK_W-1:0] qty_r, qty_s, stock_rd_s;
    logic [MONEY_W-1:0] money_r, money_s, mm_r, mm_s, chg_r, chg_s, change_r, change_s;
    logic [COST_W-1:0]  cost_r, cost_s;
    logic [2:0]         err_r, err_s, err_code_r, err_code_s;
    logic               cust_ack_r, cust_ack_s, op_ack_r, op_ack_s, disp_valid_r, disp_valid_s;
    logic               change_valid_r, change_valid_s, done_r, done_s, busy_r, busy_s;
    logic               dec_en_s, add_en_s, add_ovf_s;
`ifdef VEND_DISP_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall_r, stall_s;
    logic [STOCK_W-1:0] sold_r, sold_s;
    logic [COST_W-1:0]  charge_s;
`endif

    vend_stock_bank #(.STOCK_W(STOCK_W)) u_bank (
        .clk(clk), .rst_n(rst_n),
        .rd_type(type_r), .rd_data(stock_rd_s),
        .dec_en(dec_en_s), .dec_type(type_r),
        .add_en(add_en_s), .add_type(type_r), .add_qty(qty_r), .add_ovf(add_ovf_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;   is_cust_s = is_cust_r; prio_op_s = prio_op_r; type_s = type_r;
        qty_s = qty_r;       money_s = money_r;     mm_s = mm_r;           chg_s = chg_r;
        cost_s = cost_r;     err_s = err_r;         err_code_s = err_code_r;
        change_s = change_r; cust_ack_s = 1'b0;     op_ack_s = 1'b0;       done_s = 1'b0;
        change_valid_s = 1'b0; dec_en_s = 1'b0;     add_en_s = 1'b0;
`ifdef VEND_DISP_TIMEOUT_EN
        stall_s = stall_r;   sold_s = sold_r;       charge_s = '0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cust_req && (!op_req || !prio_op_r)) begin
                    cust_ack_s = 1'b1; is_cust_s = 1'b1; prio_op_s = 1'b1;
                    type_s = cust_type; qty_s = cust_qty; money_s = cust_money;
                    cost_s = calc_cost(cust_type, COST_W'(cust_qty));
                    state_s = ST_CHECK;
                end else if (op_req) begin
                    op_ack_s = 1'b1; is_cust_s = 1'b0; prio_op_s = 1'b0;
                    type_s = op_type; qty_s = op_qty; money_s = '0; cost_s = '0;
                    state_s = ST_RESTOCK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                chg_s   = money_r;
                state_s = ST_FINISH;
`ifdef VEND_DISP_TIMEOUT_EN
                stall_s = '0; sold_s = '0;
`endif
                if (qty_r == STOCK_W'(0))                      err_s = ERR_BAD_QTY;
                else if (stock_rd_s < qty_r)                   err_s = ERR_NO_STOCK;
                else if (COST_W'(money_r) < cost_r)            err_s = ERR_NO_FUNDS;
                else if (COST_W'(mm_r) + cost_r > MONEY_MAX)   err_s = ERR_MONEY_OVF;
                else begin
                    err_s = ERR_OK; state_s = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (disp_ready) begin
                    dec_en_s = 1'b1;
                    qty_s    = qty_r - STOCK_W'(1);
`ifdef VEND_DISP_TIMEOUT_EN
                    stall_s = '0; sold_s = sold_r + STOCK_W'(1);
`endif
                    if (qty_r == STOCK_W'(1)) begin
                        mm_s    = mm_r + MONEY_W'(cost_r);
                        chg_s   = money_r - MONEY_W'(cost_r);
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_DISPENSE;
                    end
                end else begin
`ifdef VEND_DISP_TIMEOUT_EN
                    // Stalled dispenser: bill only what was actually handed over
                    if (stall_r == STALL_W'(TIMEOUT_CYC - 1)) begin
                        charge_s = calc_cost(type_r, COST_W'(sold_r));
                        mm_s     = mm_r + MONEY_W'(charge_s);
                        chg_s    = money_r - MONEY_W'(charge_s);
                        err_s    = ERR_TIMEOUT;
                        state_s  = ST_FINISH;
                    end else begin
                        stall_s = stall_r + STALL_W'(1);
                    end
`else
                    state_s = ST_DISPENSE;
`endif
                end
            end
            ST_RESTOCK: begin
                add_en_s = 1'b1;
                err_s    = add_ovf_s ? ERR_STOCK_FULL : ERR_OK;
                chg_s    = '0;
                state_s  = ST_FINISH;
            end
            ST_FINISH: begin
                done_s         = 1'b1;
                err_code_s     = err_r;
                change_valid_s = is_cust_r;
                change_s       = is_cust_r ? chg_r : '0;
                state_s        = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
        disp_valid_s = (state_s == ST_DISPENSE);
        busy_s       = (state_s != ST_IDLE);
    end

    // State, transaction context and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;  is_cust_r <= 1'b0; prio_op_r <= 1'b0; type_r <= '0;
            qty_r <= '0;         money_r <= '0;     mm_r <= '0;        chg_r <= '0;
            cost_r <= '0;        err_r <= ERR_OK;   err_code_r <= ERR_OK; change_r <= '0;
            cust_ack_r <= 1'b0;  op_ack_r <= 1'b0;  disp_valid_r <= 1'b0;
            change_valid_r <= 1'b0; done_r <= 1'b0; busy_r <= 1'b0;
`ifdef VEND_DISP_TIMEOUT_EN
            stall_r <= '0;       sold_r <= '0;
`endif
        end else begin
            state_r <= state_s;  is_cust_r <= is_cust_s; prio_op_r <= prio_op_s; type_r <= type_s;
            qty_r <= qty_s;      money_r <= money_s;     mm_r <= mm_s;           chg_r <= chg_s;
            cost_r <= cost_s;    err_r <= err_s;         err_code_r <= err_code_s; change_r <= change_s;
            cust_ack_r <= cust_ack_s; op_ack_r <= op_ack_s; disp_valid_r <= disp_valid_s;
            change_valid_r <= change_valid_s; done_r <= done_s; busy_r <= busy_s;
`ifdef VEND_DISP_TIMEOUT_EN
            stall_r <= stall_s;  sold_r <= sold_s;
`endif
        end
    end

    assign cust_ack      = cust_ack_r;
    assign op_ack        = op_ack_r;
    assign disp_valid    = disp_valid_r;
    assign disp_type     = type_r;
    assign change        = change_r;
    assign change_valid  = change_valid_r;
    assign done          = done_r;
    assign err_code      = err_code_r;
    assign machine_money = mm_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller: vector table, corner sequences, randomized model check.
module tb_vend_txn_controller;
    localparam int TMO = 16;

    logic       clk = 1'b0, rst_n;
    logic       cust_req, op_req, disp_ready;
    logic [2:0] cust_type, op_type, disp_type, err_code;
    logic [3:0] cust_qty, op_qty;
    logic [6:0] cust_money, change, machine_money;
    logic       cust_ack, op_ack, disp_valid, change_valid, done, busy;

    always #5 clk = ~clk;

    vend_txn_controller #(.STOCK_W(4), .MONEY_W(7), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cust_req(cust_req), .cust_type(cust_type), .cust_qty(cust_qty), .cust_money(cust_money),
        .cust_ack(cust_ack), .op_req(op_req), .op_type(op_type), .op_qty(op_qty), .op_ack(op_ack),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_ready(disp_ready),
        .change(change), .change_valid(change_valid), .done(done), .err_code(err_code),
        .machine_money(machine_money), .busy(busy)
    );

    int total = 0, bad = 0;
    int stock_m[8];
    int mm_m;
    bit tie_cust_m;
    int price_tab[8] = '{5, 8, 10, 12, 15, 20, 25, 30};

    typedef struct {
        bit cust; int t; int q; int m; int e; int ch; int mm; int lat;
    } vec_t;
    vec_t tab[19];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [25:0] all_outs();
        return {cust_ack, op_ack, disp_valid, disp_type, change, change_valid, done,
                err_code, machine_money, busy};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) stock_m[i] = 0;
        mm_m = 0;
        tie_cust_m = 1'b1;
    endtask

    // Transaction-level reference: sold >= 0 means the dispenser stalled after that many items
    task automatic model_txn(input bit cust, input int t, input int q, input int m, input int sold,
                             output int e, output int ch, output int items);
        int cost;
        cost = price_tab[t] * q;
        items = 0;
        ch = 0;
        if (!cust) begin
            if (stock_m[t] + q > 15) e = 5;
            else begin stock_m[t] += q; e = 0; end
        end else begin
            ch = m;
            if (q == 0)                 e = 1;
            else if (stock_m[t] < q)    e = 2;
            else if (m < cost)          e = 3;
            else if (mm_m + cost > 127) e = 4;
            else if (sold >= 0) begin
                e = 6; items = sold; stock_m[t] -= sold;
                mm_m += price_tab[t] * sold; ch = m - price_tab[t] * sold;
            end else begin
                e = 0; items = q; stock_m[t] -= q; mm_m += cost; ch = m - cost;
            end
        end
        tie_cust_m = !cust;
    endtask

    // mode 0: ready always high, 1: ready random, 2: ready only for the first item
    task automatic run_txn(input bit cust, input int t, input int q, input int m, input int mode,
                           output int e, output int ch, output int cv, output int items,
                           output int vcyc, output int lat, output int ok);
        bit got_ack, fin;
        @(negedge clk);
        if (cust) begin
            cust_type = 3'(t); cust_qty = 4'(q); cust_money = 7'(m); cust_req = 1'b1;
        end else begin
            op_type = 3'(t); op_qty = 4'(q); op_req = 1'b1;
        end
        e = -1; ch = -1; cv = 0; items = 0; vcyc = 0; lat = 0; ok = 1; got_ack = 0; fin = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            lat++;
            if (cust_ack || op_ack) begin
                if (got_ack || cust_ack !== cust || op_ack !== !cust) ok = 0;
                got_ack = 1; cust_req = 1'b0; op_req = 1'b0;
            end
            if (change_valid && !done) ok = 0;
            if (done) begin fin = 1; e = err_code; ch = change; cv = change_valid; end
            if (disp_valid) begin vcyc++; if (disp_type !== 3'(t)) ok = 0; end
            case (mode)
                0:       disp_ready = 1'b1;
                1:       disp_ready = ($urandom_range(3) != 0);
                default: disp_ready = (items == 0);
            endcase
            if (disp_valid && disp_ready) items++;
        end
        if (!got_ack) ok = 0;
        cust_req = 1'b0; op_req = 1'b0; disp_ready = 1'b0;
    endtask

    task automatic tie_test(input string tag);
        int ca, oa, d1, dn, e, ch, it;
        bit exp_cust;
        exp_cust = tie_cust_m;
        @(negedge clk);
        cust_type = 3'd0; cust_qty = 4'd0; cust_money = 7'd9; op_type = 3'd5; op_qty = 4'd0;
        cust_req = 1'b1; op_req = 1'b1;
        ca = -1; oa = -1; d1 = -1; dn = 0;
        for (int c = 1; c <= 40 && dn < 2; c++) begin
            @(negedge clk);
            if (cust_ack) begin ca = c; cust_req = 1'b0; end
            if (op_ack)   begin oa = c; op_req = 1'b0; end
            if (done) begin if (dn == 0) d1 = c; dn++; end
        end
        cust_req = 1'b0; op_req = 1'b0;
        chk({tag, "_dones"}, dn, 2);
        chk({tag, "_both_acked"}, int'(ca > 0 && oa > 0), 1);
        chk({tag, "_cust_first"}, int'(ca > 0 && (oa < 0 || ca < oa)), int'(exp_cust));
        chk({tag, "_second_after_done"}, int'(d1 > 0 && (exp_cust ? oa : ca) > d1), 1);
        if (exp_cust) begin
            model_txn(1'b1, 0, 0, 9, -1, e, ch, it); model_txn(1'b0, 5, 0, 0, -1, e, ch, it);
        end else begin
            model_txn(1'b0, 5, 0, 0, -1, e, ch, it); model_txn(1'b1, 0, 0, 9, -1, e, ch, it);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int e, ch, cv, items, vcyc, lat, ok, me, mch, mit, wait_c, cust_i;
        cust_req = 1'b0; op_req = 1'b0; disp_ready = 1'b0;
        cust_type = 3'd0; cust_qty = 4'd0; cust_money = 7'd0; op_type = 3'd0; op_qty = 4'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(all_outs()), 0);
        rst_n = 1'b1;

        //            cust  t  q   m    e  ch   mm  lat
        tab[0]  = '{1'b0, 2,  5,   0, 0,  0,   0, 3};
        tab[1]  = '{1'b1, 2,  3,  50, 0, 20,  30, 6};
        tab[2]  = '{1'b1, 2,  3,  50, 2, 50,  30, 3};
        tab[3]  = '{1'b0, 2, 14,   0, 5,  0,  30, 3};
        tab[4]  = '{1'b0, 0,  1,   0, 0,  0,  30, 3};
        tab[5]  = '{1'b1, 0,  1,   4, 3,  4,  30, 3};
        tab[6]  = '{1'b1, 2,  2,  20, 0,  0,  50, 5};
        tab[7]  = '{1'b1, 2,  1,  10, 2, 10,  50, 3};
        tab[8]  = '{1'b1, 2,  0,  10, 1, 10,  50, 3};
        tab[9]  = '{1'b0, 7, 15,   0, 0,  0,  50, 3};
        tab[10] = '{1'b1, 7,  3, 100, 4, 100, 50, 3};
        tab[11] = '{1'b1, 7,  2,  70, 0, 10, 110, 5};
        tab[12] = '{1'b0, 7,  2,   0, 0,  0, 110, 3};
        tab[13] = '{1'b0, 7,  1,   0, 5,  0, 110, 3};
        tab[14] = '{1'b0, 3,  1,   0, 0,  0, 110, 3};
        tab[15] = '{1'b1, 0,  1,   5, 0,  0, 115, 4};
        tab[16] = '{1'b1, 3,  1,  12, 0,  0, 127, 4};
        tab[17] = '{1'b0, 4,  0,   0, 0,  0, 127, 3};
        tab[18] = '{1'b1, 7,  1, 127, 4, 127, 127, 3};

        for (int i = 0; i < 19; i++) begin
            run_txn(tab[i].cust, tab[i].t, tab[i].q, tab[i].m, 0, e, ch, cv, items, vcyc, lat, ok);
            model_txn(tab[i].cust, tab[i].t, tab[i].q, tab[i].m, -1, me, mch, mit);
            chk($sformatf("vec%0d_err", i), e, tab[i].e);
            chk($sformatf("vec%0d_change_valid", i), cv, int'(tab[i].cust));
            if (tab[i].cust) chk($sformatf("vec%0d_change", i), ch, tab[i].ch);
            chk($sformatf("vec%0d_money", i), int'(machine_money), tab[i].mm);
            chk($sformatf("vec%0d_items", i), vcyc, (tab[i].cust && tab[i].e == 0) ? tab[i].q : 0);
            chk($sformatf("vec%0d_latency", i), lat, tab[i].lat);
            chk($sformatf("vec%0d_protocol", i), ok, 1);
        end

        tie_test("tie_after_cust");

        // Reset in the middle of a dispense
        do_reset();
        run_txn(1'b0, 1, 2, 0, 0, e, ch, cv, items, vcyc, lat, ok);
        model_txn(1'b0, 1, 2, 0, -1, me, mch, mit);
        run_txn(1'b1, 1, 1, 8, 0, e, ch, cv, items, vcyc, lat, ok);
        model_txn(1'b1, 1, 1, 8, -1, me, mch, mit);
        chk("pre_reset_money", int'(machine_money), mm_m);
        @(negedge clk);
        cust_type = 3'd1; cust_qty = 4'd1; cust_money = 7'd8; cust_req = 1'b1; disp_ready = 1'b0;
        wait_c = 0;
        while (!disp_valid && wait_c < 20) begin
            @(negedge clk); wait_c++;
            if (cust_ack) cust_req = 1'b0;
        end
        cust_req = 1'b0;
        chk("mid_dispense_valid", int'(disp_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(all_outs()), 0);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        run_txn(1'b1, 1, 1, 8, 0, e, ch, cv, items, vcyc, lat, ok);
        model_txn(1'b1, 1, 1, 8, -1, me, mch, mit);
        chk("post_reset_stock_err", e, me);

        tie_test("tie_after_reset");

`ifdef VEND_DISP_TIMEOUT_EN
        run_txn(1'b0, 2, 3, 0, 0, e, ch, cv, items, vcyc, lat, ok);
        model_txn(1'b0, 2, 3, 0, -1, me, mch, mit);
        run_txn(1'b1, 2, 3, 50, 2, e, ch, cv, items, vcyc, lat, ok);
        model_txn(1'b1, 2, 3, 50, 1, me, mch, mit);
        chk("timeout_err", e, 6);
        chk("timeout_change", ch, 40);
        chk("timeout_items", items, 1);
        chk("timeout_money", int'(machine_money), mm_m);
`endif

        for (int n = 0; n < 80; n++) begin
            int t, q, m;
            if (n == 40) do_reset();
            cust_i = ($urandom_range(2) != 0) ? 1 : 0;
            t = $urandom_range(7);
            q = cust_i ? $urandom_range(4) : $urandom_range(9);
            m = $urandom_range(127);
            run_txn(cust_i[0], t, q, m, 1, e, ch, cv, items, vcyc, lat, ok);
            model_txn(cust_i[0], t, q, m, -1, me, mch, mit);
            chk($sformatf("rnd%0d_err", n), e, me);
            chk($sformatf("rnd%0d_change_valid", n), cv, cust_i);
            if (cust_i != 0) chk($sformatf("rnd%0d_change", n), ch, mch);
            chk($sformatf("rnd%0d_items", n), items, mit);
            chk($sformatf("rnd%0d_money", n), int'(machine_money), mm_m);
            chk($sformatf("rnd%0d_protocol", n), ok, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
